// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor that consumes WIDTH-bit operands DIGIT bits per clock,
// carrying between digits through a register; start/busy/done handshake, signed overflow.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   digit_sum_s;
    logic [WIDTH-1:0] sum_ext_s;
    logic [WIDTH-1:0] res_next_s;

    // Current digit sum and the result word with that digit shifted in at the MSB end.
    always_comb begin
        digit_sum_s = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
        sum_ext_s   = WIDTH'(digit_sum_s[DIGIT-1:0]);
        res_next_s  = (res_q >> DIGIT) | (sum_ext_s << (WIDTH - DIGIT));
    end

    // Next-state and next-output computation for the IDLE/RUN sequencer.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + ~Cin, so the carry seed is Cin XOR Sub.
                    opa_d   = A;
                    opb_d   = Sub ? ~B : B;
                    carry_d = Cin ^ Sub;
                    cnt_d   = {CNT_W{1'b0}};
                    res_d   = {WIDTH{1'b0}};
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                carry_d = digit_sum_s[DIGIT];
                res_d   = res_next_s;
                if (cnt_q == LAST) begin
                    // The low digit now holds the operands' original top bits.
                    s_d     = res_next_s;
                    cout_d  = digit_sum_s[DIGIT];
                    ovf_d   = (opa_q[DIGIT-1] == opb_q[DIGIT-1]) &&
                              (digit_sum_s[DIGIT-1] != opa_q[DIGIT-1]);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder at DIGIT=4, 1 and 16 (WIDTH=16).
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_v;
    logic [15:0] a_v, b_v;
    logic        cin_v, sub_v;
    int          sel;
    int          errors = 0;
    int          checks = 0;

    logic        busy4, done4, cout4, ovf4;
    logic [15:0] s4;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] s1;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] s16;

    logic        cur_busy, cur_done, cur_cout, cur_ovf;
    logic [15:0] cur_s;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v && (sel == 4)),
        .A(a_v), .B(b_v), .Cin(cin_v), .Sub(sub_v),
        .busy(busy4), .done(done4), .S(s4), .Cout(cout4), .Ovf(ovf4));

    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v && (sel == 1)),
        .A(a_v), .B(b_v), .Cin(cin_v), .Sub(sub_v),
        .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .Ovf(ovf1));

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start_v && (sel == 16)),
        .A(a_v), .B(b_v), .Cin(cin_v), .Sub(sub_v),
        .busy(busy16), .done(done16), .S(s16), .Cout(cout16), .Ovf(ovf16));

    always_comb begin
        case (sel)
            1:       begin cur_busy = busy1;  cur_done = done1;  cur_s = s1;  cur_cout = cout1;  cur_ovf = ovf1;  end
            16:      begin cur_busy = busy16; cur_done = done16; cur_s = s16; cur_cout = cout16; cur_ovf = ovf16; end
            default: begin cur_busy = busy4;  cur_done = done4;  cur_s = s4;  cur_cout = cout4;  cur_ovf = ovf4;  end
        endcase
    end

    // Independent whole-word reference: {S, Cout, Ovf}.
    function automatic logic [17:0] ref_op(input logic [15:0] a, b, input logic cin, sub);
        logic [15:0] bb;
        logic [16:0] full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'h0000, cin ^ sub};
        return {full[15:0], full[16], (a[15] == bb[15]) && (full[15] != a[15])};
    endfunction

    task automatic launch(input logic [15:0] a, b, input logic cin, sub);
        a_v = a; b_v = b; cin_v = cin; sub_v = sub; start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (cur_done !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [15:0] a, b, input logic cin, sub, output int lat);
        @(negedge clk);
        launch(a, b, cin, sub);
        wait_done(lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy4, done4, s4, cout4, ovf4} !== 20'h00000) begin
            errors++; $display("FAIL reset_d4: got %h expected 00000", {busy4, done4, s4, cout4, ovf4});
        end
        checks++;
        if ({busy1, done1, s1, cout1, ovf1, busy16, done16, s16, cout16, ovf16} !== 40'h0) begin
            errors++; $display("FAIL reset_d1_d16: got %h expected 0",
                {busy1, done1, s1, cout1, ovf1, busy16, done16, s16, cout16, ovf16});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset: got %b expected 00", {busy4, done4});
        end
    endtask

    task automatic test_add();
        int lat;
        sel = 4;
        @(negedge clk);
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        checks++;
        if (cur_busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_accept: got %b expected 1", cur_busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL latency_d4: got %0d expected 4", lat);
        end
        checks++;
        if ({cur_s, cur_cout, cur_ovf, cur_busy} !== {16'h5555, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL add_5555: got %h/%b/%b busy=%b expected 5555/0/0 busy=0",
                cur_s, cur_cout, cur_ovf, cur_busy);
        end
        @(negedge clk);
        checks++;
        if ({cur_done, cur_s} !== {1'b0, 16'h5555}) begin
            errors++; $display("FAIL done_one_cycle: got done=%b S=%h expected done=0 S=5555", cur_done, cur_s);
        end
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++;
        if ({cur_s, cur_cout, cur_ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_wrap: got %h/%b/%b expected 0000/1/0", cur_s, cur_cout, cur_ovf);
        end
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++;
        if ({cur_s, cur_cout, cur_ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL add_ovf: got %h/%b/%b expected 8000/0/1", cur_s, cur_cout, cur_ovf);
        end
    endtask

    task automatic test_sub();
        int lat;
        sel = 4;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
        checks++;
        if ({cur_s, cur_cout, cur_ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_borrow: got %h/%b/%b expected FFFE/0/0", cur_s, cur_cout, cur_ovf);
        end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        checks++;
        if ({cur_s, cur_cout, cur_ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
            errors++; $display("FAIL sub_ovf: got %h/%b/%b expected 7FFF/1/1", cur_s, cur_cout, cur_ovf);
        end
        run_op(16'h0010, 16'h0001, 1'b1, 1'b1, lat);
        checks++;
        if ({cur_s, cur_cout, cur_ovf} !== {16'h000E, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sub_cin: got %h/%b/%b expected 000E/1/0", cur_s, cur_cout, cur_ovf);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        sel = 4;
        @(negedge clk);
        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        wait_done(lat);
        checks++;
        if ({lat[7:0], cur_s, cur_cout, cur_ovf} !== {8'd3, 16'h3333, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ignore_start: got lat=%0d %h/%b/%b expected lat=3 3333/0/0",
                lat, cur_s, cur_cout, cur_ovf);
        end
        repeat (6) @(negedge clk);
        checks++;
        if ({cur_busy, cur_s} !== {1'b0, 16'h3333}) begin
            errors++; $display("FAIL no_queued_op: got busy=%b S=%h expected busy=0 S=3333", cur_busy, cur_s);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        sel = 4;
        run_op(16'h0100, 16'h0200, 1'b0, 1'b0, lat);
        launch(16'h0003, 16'h0001, 1'b0, 1'b1);
        checks++;
        if ({cur_done, cur_busy, cur_s} !== {1'b0, 1'b1, 16'h0300}) begin
            errors++; $display("FAIL b2b_accept: got done=%b busy=%b S=%h expected done=0 busy=1 S=0300",
                cur_done, cur_busy, cur_s);
        end
        @(negedge clk);
        checks++;
        if (cur_s !== 16'h0300) begin
            errors++; $display("FAIL b2b_hold: got %h expected 0300", cur_s);
        end
        wait_done(lat);
        checks++;
        if ({lat[7:0], cur_s, cur_cout, cur_ovf} !== {8'd3, 16'h0002, 1'b1, 1'b0}) begin
            errors++; $display("FAIL b2b_second: got lat=%0d %h/%b/%b expected lat=3 0002/1/0",
                lat, cur_s, cur_cout, cur_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        sel = 4;
        @(negedge clk);
        launch(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({cur_busy, cur_done, cur_s, cur_cout, cur_ovf} !== 20'h00000) begin
            errors++; $display("FAIL async_reset: got %h expected 00000",
                {cur_busy, cur_done, cur_s, cur_cout, cur_ovf});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (cur_done === 1'b1 || cur_busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL no_done_after_abort: got %0d active cycles expected 0", seen);
        end
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, lat);
        checks++;
        if ({lat[7:0], cur_s, cur_cout, cur_ovf} !== {8'd4, 16'h1010, 1'b0, 1'b0}) begin
            errors++; $display("FAIL after_abort: got lat=%0d %h/%b/%b expected lat=4 1010/0/0",
                lat, cur_s, cur_cout, cur_ovf);
        end
    endtask

    task automatic test_digit_widths();
        int lat;
        sel = 1;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        checks++;
        if ({lat[7:0], cur_s, cur_cout, cur_ovf} !== {8'd16, 16'h5555, 1'b0, 1'b0}) begin
            errors++; $display("FAIL d1_add: got lat=%0d %h/%b/%b expected lat=16 5555/0/0",
                lat, cur_s, cur_cout, cur_ovf);
        end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        checks++;
        if ({cur_s, cur_cout, cur_ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
            errors++; $display("FAIL d1_sub: got %h/%b/%b expected 7FFF/1/1", cur_s, cur_cout, cur_ovf);
        end
        sel = 16;
        run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, lat);
        checks++;
        if ({lat[7:0], cur_s, cur_cout, cur_ovf} !== {8'd1, 16'h0001, 1'b1, 1'b0}) begin
            errors++; $display("FAIL d16_add: got lat=%0d %h/%b/%b expected lat=1 0001/1/0",
                lat, cur_s, cur_cout, cur_ovf);
        end
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
        checks++;
        if ({cur_s, cur_cout, cur_ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
            errors++; $display("FAIL d16_sub: got %h/%b/%b expected FFFE/0/0", cur_s, cur_cout, cur_ovf);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] a, b;
        logic        cin, sub;
        logic [17:0] exp;
        int          sels[3] = '{4, 1, 16};
        for (int k = 0; k < 3; k++) begin
            sel = sels[k];
            for (int i = 0; i < 6; i++) begin
                a   = 16'($urandom);
                b   = 16'($urandom);
                cin = 1'($urandom_range(1, 0));
                sub = 1'($urandom_range(1, 0));
                exp = ref_op(a, b, cin, sub);
                run_op(a, b, cin, sub, lat);
                checks++;
                if ({cur_s, cur_cout, cur_ovf} !== exp) begin
                    errors++; $display("FAIL random_d%0d: A=%h B=%h cin=%b sub=%b got %h expected %h",
                        sel, a, b, cin, sub, {cur_s, cur_cout, cur_ovf}, exp);
                end
            end
        end
    endtask

    initial begin
        sel = 4; start_v = 1'b0; a_v = 16'h0000; b_v = 16'h0000; cin_v = 1'b0; sub_v = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_digit_widths();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
